// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 1-bit taken history per entry.
// Lookup is combinational on the fetch PC; training arrives from EX.
module branch_target_buffer #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic [31:0] PredNPCF,
  output logic [1:0]  BranchFlagsF,
  input  logic        UpdateEnE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        BranchTakenE,
  input  logic [1:0]  BranchFlagsE,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int DEPTH = 2 ** INDEX_W;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] hist_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic [31:0] branchCount_q;
  logic [31:0] branchCount_d;
  logic [31:0] missCount_q;
  logic [31:0] missCount_d;

  logic [INDEX_W-1:0] idxF;
  logic [TAG_W-1:0]   tagF;
  logic               hitF;

  logic [INDEX_W-1:0] idxE;
  logic [TAG_W-1:0]   tagE;
  logic               hitE;
  logic               allocE;
  logic               writeTargetE;
  logic               writeHistE;
  logic               mispredictE;

  assign idxF = PCF[INDEX_W+1:2];
  assign tagF = PCF[31:INDEX_W+2];
  assign idxE = PCE[INDEX_W+1:2];
  assign tagE = PCE[31:INDEX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign hitF         = valid_q[idxF] && (tag_q[idxF] == tagF);
  assign BranchFlagsF = {hitF, hitF & hist_q[idxF]};
  assign PredNPCF     = (BranchFlagsF == 2'b11) ? target_q[idxF] : (PCF + 32'd4);

  assign hitE         = valid_q[idxE] && (tag_q[idxE] == tagE);
  assign allocE       = UpdateEnE && !hitE && BranchTakenE;
  assign writeTargetE = UpdateEnE && BranchTakenE;
  assign writeHistE   = UpdateEnE && (hitE || BranchTakenE);
  assign mispredictE  = BranchTakenE != BranchFlagsE[0];

  always_comb begin
    valid_d = valid_q;
    if (allocE) begin
      valid_d[idxE] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload arrays carry no reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk) begin
    if (!rst && writeTargetE) begin
      tag_q[idxE]    <= tagE;
      target_q[idxE] <= BrTargetE;
    end
    if (!rst && writeHistE) begin
      hist_q[idxE] <= BranchTakenE;
    end
  end

  always_comb begin
    branchCount_d = branchCount_q;
    missCount_d   = missCount_q;
    if (UpdateEnE) begin
      if (branchCount_q != 32'hFFFF_FFFF) begin
        branchCount_d = branchCount_q + 32'd1;
      end
      if (mispredictE && (missCount_q != 32'hFFFF_FFFF)) begin
        missCount_d = missCount_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branchCount_q <= '0;
      missCount_q   <= '0;
    end else begin
      branchCount_q <= branchCount_d;
      missCount_q   <= missCount_d;
    end
  end

  assign BranchCount = branchCount_q;
  assign MissCount   = missCount_q;

  logic unused_bits;
  assign unused_bits = ^{PCF[1:0], PCE[1:0], BranchFlagsE[1]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table,
// randomized traffic against a word-address keyed model, and edge sequences.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] PredNPCF;
  logic [1:0]  BranchFlagsF;
  logic        UpdateEnE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        BranchTakenE;
  logic [1:0]  BranchFlagsE;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;

  int testsRun = 0;
  int testsFailed = 0;

  branch_target_buffer #(.INDEX_W(6), .TAG_W(24)) dut (
    .clk(clk),
    .rst(rst),
    .PCF(PCF),
    .PredNPCF(PredNPCF),
    .BranchFlagsF(BranchFlagsF),
    .UpdateEnE(UpdateEnE),
    .PCE(PCE),
    .BrTargetE(BrTargetE),
    .BranchTakenE(BranchTakenE),
    .BranchFlagsE(BranchFlagsE),
    .BranchCount(BranchCount),
    .MissCount(MissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each slot remembers the full word address it was trained on.
  localparam int ENTRIES = 64;
  bit          mValid  [ENTRIES];
  logic [29:0] mWord   [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  bit          mHist   [ENTRIES];
  longint      mBranches;
  longint      mMisses;

  typedef struct packed {
    logic [31:0] pcf;
    logic        upd;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic        taken;
    logic [1:0]  flagsE;
    logic [1:0]  expFlags;
    logic [31:0] expNpc;
    logic [31:0] expBranches;
    logic [31:0] expMisses;
  } vec_t;

  vec_t vecs [14];

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, output logic [1:0] flags,
                                       output logic [31:0] npc);
    int  s;
    bit  hit;
    s     = slotOf(pc);
    hit   = mValid[s] && (mWord[s] == pc[31:2]);
    flags = {hit, hit && mHist[s]};
    npc   = (flags == 2'b11) ? mTarget[s] : pc + 32'd4;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
    mBranches = 0;
    mMisses   = 0;
  endfunction

  function automatic void modelEdge(input logic resetNow, input logic upd, input logic [31:0] pce,
                                    input logic [31:0] tgt, input logic taken,
                                    input logic [1:0] flagsE);
    int s;
    bit hit;
    if (resetNow) begin
      modelClear();
      return;
    end
    if (!upd) return;
    if (mBranches < 64'hFFFF_FFFF) mBranches++;
    if ((taken != flagsE[0]) && (mMisses < 64'hFFFF_FFFF)) mMisses++;
    s   = slotOf(pce);
    hit = mValid[s] && (mWord[s] == pce[31:2]);
    if (taken) begin
      mValid[s]  = 1'b1;
      mWord[s]   = pce[31:2];
      mTarget[s] = tgt;
      mHist[s]   = 1'b1;
    end else if (hit) begin
      mHist[s] = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                               input logic [31:0] tgt, input logic taken,
                               input logic [1:0] flagsE);
    PCF          = pcf;
    UpdateEnE    = upd;
    PCE          = pce;
    BrTargetE    = tgt;
    BranchTakenE = taken;
    BranchFlagsE = flagsE;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelEdge(rst, UpdateEnE, PCE, BrTargetE, BranchTakenE, BranchFlagsE);
    #1;
  endtask

  task automatic checkLookupVsModel(input string tag);
    logic [1:0]  ef;
    logic [31:0] en;
    modelPredict(PCF, ef, en);
    checkOutput({tag, "_flags"}, {30'd0, BranchFlagsF}, {30'd0, ef});
    checkOutput({tag, "_npc"}, PredNPCF, en);
  endtask

  task automatic checkCountersVsModel(input string tag);
    checkOutput({tag, "_bcount"}, BranchCount, mBranches[31:0]);
    checkOutput({tag, "_mcount"}, MissCount, mMisses[31:0]);
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] hi;
    hi = ($urandom_range(0, 3) == 0) ? 32'hF000_0000 : 32'h0;
    return hi | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // pcf, upd, pce, tgt, taken, flagsE, expFlags, expNpc, expBranches, expMisses
    vecs[0]  = '{32'h100, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b00, 32'h104, 32'd0, 32'd0};
    vecs[1]  = '{32'h100, 1'b1, 32'h100, 32'h80,   1'b1, 2'b00, 2'b00, 32'h104, 32'd1, 32'd1};
    vecs[2]  = '{32'h100, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b11, 32'h80,  32'd1, 32'd1};
    vecs[3]  = '{32'h100, 1'b1, 32'h100, 32'hDEAD, 1'b0, 2'b11, 2'b11, 32'h80,  32'd2, 32'd2};
    vecs[4]  = '{32'h100, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b10, 32'h104, 32'd2, 32'd2};
    vecs[5]  = '{32'h200, 1'b1, 32'h200, 32'h999,  1'b0, 2'b00, 2'b00, 32'h204, 32'd3, 32'd2};
    vecs[6]  = '{32'h200, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b00, 32'h204, 32'd3, 32'd2};
    vecs[7]  = '{32'h100, 1'b1, 32'h100, 32'h80,   1'b1, 2'b10, 2'b10, 32'h104, 32'd4, 32'd3};
    vecs[8]  = '{32'h100, 1'b1, 32'h200, 32'h300,  1'b1, 2'b00, 2'b11, 32'h80,  32'd5, 32'd4};
    vecs[9]  = '{32'h100, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b00, 32'h104, 32'd5, 32'd4};
    vecs[10] = '{32'h200, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b11, 32'h300, 32'd5, 32'd4};
    vecs[11] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0,  32'd5, 32'd4};
    vecs[12] = '{32'h202, 1'b0, 32'h200, 32'h444,  1'b1, 2'bxx, 2'b11, 32'h300, 32'd5, 32'd4};
    vecs[13] = '{32'h104, 1'b0, 32'h0,   32'h0,    1'b0, 2'b00, 2'b00, 32'h108, 32'd5, 32'd4};

    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    modelClear();
    repeat (2) clockEdge();
    rst = 1'b0;

    checkOutput("reset_bcount", BranchCount, 32'd0);
    checkOutput("reset_mcount", MissCount, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].pcf, vecs[i].upd, vecs[i].pce, vecs[i].tgt, vecs[i].taken,
                    vecs[i].flagsE);
      checkOutput($sformatf("vec%0d_flags", i), {30'd0, BranchFlagsF}, {30'd0, vecs[i].expFlags});
      checkOutput($sformatf("vec%0d_npc", i), PredNPCF, vecs[i].expNpc);
      clockEdge();
      checkOutput($sformatf("vec%0d_bcount", i), BranchCount, vecs[i].expBranches);
      checkOutput($sformatf("vec%0d_mcount", i), MissCount, vecs[i].expMisses);
    end

    // Random traffic: EX flags usually echo what IF would predict, sometimes not.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pce;
      logic [1:0]  pf;
      logic [31:0] pn;
      logic [1:0]  fe;
      pce = randPc();
      modelPredict(pce, pf, pn);
      fe = pf;
      if ($urandom_range(0, 3) == 0) begin
        fe = ($urandom_range(0, 1) == 0) ? 2'b10 : {1'b0, 1'b0} | 2'(($urandom_range(0, 1)) * 3);
      end
      applyStimulus(randPc(), 1'($urandom_range(0, 3) != 0), pce, $urandom & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)), fe);
      checkLookupVsModel("rnd");
      clockEdge();
      checkCountersVsModel("rnd");
    end

    // Counter saturation: preload near the top, then keep mispredicting.
    applyStimulus(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    force dut.branchCount_q = 32'hFFFF_FFFE;
    force dut.missCount_q   = 32'hFFFF_FFFE;
    #1;
    release dut.branchCount_q;
    release dut.missCount_q;
    mBranches = 64'hFFFF_FFFE;
    mMisses   = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h100, 1'b1, 32'h500, 32'h600, 1'b1, 2'b00);
      clockEdge();
      checkCountersVsModel("sat");
    end
    checkOutput("sat_bcount_max", BranchCount, 32'hFFFF_FFFF);
    checkOutput("sat_mcount_max", MissCount, 32'hFFFF_FFFF);

    // Reset coinciding with a taken update must win and wipe all training.
    applyStimulus(32'h500, 1'b1, 32'h700, 32'h800, 1'b1, 2'b00);
    checkOutput("pre_rst_flags", {30'd0, BranchFlagsF}, 32'd3);
    rst = 1'b1;
    clockEdge();
    rst = 1'b0;
    applyStimulus(32'h500, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    checkOutput("rst_bcount", BranchCount, 32'd0);
    checkOutput("rst_mcount", MissCount, 32'd0);
    checkOutput("rst_flags_500", {30'd0, BranchFlagsF}, 32'd0);
    checkOutput("rst_npc_500", PredNPCF, 32'h504);
    applyStimulus(32'h700, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    checkOutput("rst_flags_700", {30'd0, BranchFlagsF}, 32'd0);
    checkOutput("rst_npc_700", PredNPCF, 32'h704);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      pc = randPc();
      applyStimulus(pc, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
      checkOutput("rst_flags_rnd", {30'd0, BranchFlagsF}, 32'd0);
      checkOutput("rst_npc_rnd", PredNPCF, pc + 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- IF-stage branch predictor: a direct-mapped BTB with one 1-bit history bit per entry.
- Looks up the fetch PC and emits the predicted next PC plus 2-bit BranchFlagsF. These flags travel down the pipeline to EX, where branch resolution compares them against the actual outcome.
- Trained from EX with each resolved conditional branch.
- Keeps branch and mispredict counters for lab statistics.

Parameters:
- INDEX_W, 6, index bits; table depth = 2**INDEX_W entries.
- TAG_W, 24, tag bits; must equal 30-INDEX_W.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- PCF  input  32  fetch PC
- PredNPCF  output  32  predicted next PC
- BranchFlagsF  output  2  {hit, predicted_taken}
- UpdateEnE  input  1  valid conditional branch resolved in EX this cycle (low when EX is stalled or bubbled)
- PCE  input  32  PC of the EX branch
- BrTargetE  input  32  computed branch target
- BranchTakenE  input  1  actual outcome
- BranchFlagsE  input  2  flags that were predicted for this branch in IF
- BranchCount  output  32  resolved branches counted
- MissCount  output  32  mispredicted branches counted

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), hist (1).
  - Valid bits are registers.
  - tag/target/hist need no reset.
- Address split: index = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2]. PC[1:0] is ignored.
- Lookup (combinational from registered state, zero latency):
  - hitF = valid[idx] && tag[idx]==tagF.
  - BranchFlagsF = {hitF, hitF & hist[idx]}. Encoding 2'b01 never occurs.
  - PredNPCF = target[idx] when BranchFlagsF==2'b11, else PCF+4 (mod 2^32, wraps from 0xFFFFFFFC to 0).
- Update, on posedge when UpdateEnE=1, keyed by PCE:
  - Hit, taken: hist<=1, target<=BrTargetE.
  - Hit, not taken: hist<=0, target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=tagE, target<=BrTargetE, hist<=1. The old entry is evicted unconditionally.
  - Miss, not taken: no table change.
  - UpdateEnE=0: no table change, counters hold.
- Same-cycle lookup and update of the same index: lookup returns the pre-edge contents. The new value is visible from the next cycle. No bypass.
- Counters, when UpdateEnE=1:
  - BranchCount +1.
  - MissCount +1 when BranchTakenE != BranchFlagsE[0].
  - Both saturate at 32'hFFFF_FFFF.
- Reset:
  - All valid<=0 and both counters<=0 on the edge where rst=1.
  - rst has priority over a simultaneous update.
  - After reset, BranchFlagsF=2'b00 and PredNPCF=PCF+4 for every PC.
  - Reset asserted mid-program discards all training.
- Unknown or X on BranchFlagsE when UpdateEnE=0 must not affect state.
- Block is stateless with respect to pipeline flushes. The hazard unit is responsible for dropping UpdateEnE on flushed EX slots.

Test Plan:
- Reset then PCF=0x0000_0100 -> BranchFlagsF=00, PredNPCF=0x0000_0104; counters=0.
- Update PCE=0x100, BrTargetE=0x80, taken, flags 00 -> next cycle PCF=0x100 gives flags 11, PredNPCF=0x80; BranchCount=1, MissCount=1.
- Update PCE=0x100 not taken, flags 11 -> PCF=0x100 gives flags 10, PredNPCF=0x104; MissCount=2. Not-taken update on miss PCE=0x200 -> PCF=0x200 still 00.
- Aliasing: train 0x100 taken (target 0x80), then PCE=0x200 with INDEX_W=6 (same index 0) taken, target 0x300 -> PCF=0x100 gives 00, PCF=0x200 gives 11/0x300.
- Same-cycle: PCF=PCE=0x100 with taken update on a cold entry -> that cycle flags 00, next cycle flags 11.
- Wrap/saturation: PCF=0xFFFF_FFFC cold -> PredNPCF=0; counters forced near max -> hold at 0xFFFF_FFFF; rst asserted concurrently with UpdateEnE -> table empty, counters 0.
